// File: rtl/gpio_pad_shift_seq.sv
// Serial engine for the GPIO pad-control chain. Each access rotates the whole
// daisy chain once: non-target pads recirculate their own bits. The target
// pad's 16-bit window is replaced MSB first, and its old contents are captured.
// Handshake: shift_req is a level held by the requester until shift_done.
// shift_done is a one-cycle pulse that acknowledges the request. The cycle
// after shift_done is always ignored, so that the requester can drop shift_req.
module gpio_pad_shift_seq #(
  parameter int NUM_PADS = 44,
  parameter int CLK_DIV  = 4
) (
  input  logic        mclk,
  input  logic        h_reset_n,
  input  logic        shift_req,
  input  logic [7:0]  cfg_pad_no,
  input  logic [15:0] cfg_shift_data,
  output logic        shift_done,
  output logic [15:0] capture_data,
  output logic        shift_rstn,
  output logic        shift_clock,
  output logic        shift_load,
  output logic        shift_data_out,
  input  logic        shift_data_in
);

  localparam int L  = NUM_PADS * 16;
  localparam int KW = $clog2(L + 1);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(L - 1);
  localparam logic [KW-1:0] LAST_BASE  = KW'(L - 16);
  localparam logic [8:0]    NUM_PADS_W = 9'(NUM_PADS);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, LOAD, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  logic [7:0]    pad_q;
  logic [15:0]   data_q;
  logic          just_done;
  logic [1:0]    sync_q;
  logic          clock_nxt, load_nxt, done_nxt;

  logic          accept, in_range, cnt_last, low_entry, in_win;
  logic [KW-1:0] step, pad_base, wstart, off;

  assign accept   = (state == IDLE) && shift_req && !just_done;
  assign in_range = {1'b0, cfg_pad_no} < NUM_PADS_W;
  assign cnt_last = (cnt == CNT_LAST);

  // Bit index of the step being set up at LOW entry, with its window position.
  assign low_entry = (state_nxt == LOW) && (state != LOW);
  assign step      = (state == HIGH) ? k + 1'b1 : k;
  assign pad_base  = KW'({pad_q, 4'b0000});
  assign wstart    = LAST_BASE - pad_base;
  assign off       = step - wstart;
  assign in_win    = (step >= wstart) && (off < KW'(16));

  // State register and registered control outputs.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state       <= IDLE;
      shift_clock <= 1'b0;
      shift_load  <= 1'b0;
      shift_done  <= 1'b0;
      shift_rstn  <= 1'b0;
      just_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift_clock <= clock_nxt;
      shift_load  <= load_nxt;
      shift_done  <= done_nxt;
      shift_rstn  <= 1'b1;
      just_done   <= (state == DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_range ? SETUP : DONE;
      SETUP:   if (cnt_last) state_nxt = LOW;
      LOW:     if (cnt_last) state_nxt = HIGH;
      HIGH:    if (cnt_last) state_nxt = (k == K_LAST) ? LOAD : LOW;
      LOAD:    if (cnt_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state, so the output registers line up with the state.
  always_comb begin
    clock_nxt = (state_nxt == HIGH);
    load_nxt  = (state_nxt == LOAD);
    done_nxt  = (state_nxt == DONE);
  end

  // Phase divider and bit counter.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      cnt <= '0;
      k   <= '0;
    end else begin
      if (state_nxt != state) cnt <= '0;
      else if (state != IDLE && state != DONE) cnt <= cnt + 1'b1;
      if (accept) k <= '0;
      else if (state == HIGH && cnt_last) k <= k + 1'b1;
    end
  end

  // Two-flop synchronizer on the returning serial data.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) sync_q <= 2'b00;
    else            sync_q <= {sync_q[0], shift_data_in};
  end

  // Request latch, serial data out and capture of the old target contents.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      pad_q          <= '0;
      data_q         <= '0;
      capture_data   <= '0;
      shift_data_out <= 1'b0;
    end else begin
      if (accept) begin
        if (in_range) begin
          pad_q  <= cfg_pad_no;
          data_q <= cfg_shift_data;
        end else begin
          capture_data <= '0;
        end
      end
      if (low_entry) begin
        if (in_win) begin
          shift_data_out <= data_q[4'd15 - off[3:0]];
          capture_data   <= {capture_data[14:0], sync_q[1]};
        end else begin
          shift_data_out <= sync_q[1];
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_pad_shift_seq.sv
// Directed bench for gpio_pad_shift_seq with 4 pads and CLK_DIV=4. A behavioural
// daisy chain of pad shift registers is attached to the serial interface.
module tb_gpio_pad_shift_seq;

  localparam int NUM_PADS = 4;
  localparam int CLK_DIV  = 4;
  localparam int L        = NUM_PADS * 16;
  localparam int LAT_FULL = 2 * CLK_DIV * (L + 1) + 1;

  logic        mclk = 1'b0;
  logic        h_reset_n = 1'b0;
  logic        shift_req = 1'b0;
  logic [7:0]  cfg_pad_no = '0;
  logic [15:0] cfg_shift_data = '0;
  logic        shift_done;
  logic [15:0] capture_data;
  logic        shift_rstn, shift_clock, shift_load, shift_data_out, shift_data_in;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_pad_shift_seq #(.NUM_PADS(NUM_PADS), .CLK_DIV(CLK_DIV)) dut (
    .mclk(mclk), .h_reset_n(h_reset_n), .shift_req(shift_req),
    .cfg_pad_no(cfg_pad_no), .cfg_shift_data(cfg_shift_data),
    .shift_done(shift_done), .capture_data(capture_data),
    .shift_rstn(shift_rstn), .shift_clock(shift_clock), .shift_load(shift_load),
    .shift_data_out(shift_data_out), .shift_data_in(shift_data_in)
  );

  // clock / reset
  always #5 mclk = ~mclk;

  // pad chain model: bit j is ring position j, position L-1 drives shift_data_in
  logic [L-1:0] chain = '0;
  logic [L-1:0] preload_val = '0;
  logic         preload_stb = 1'b0;
  always @(posedge shift_clock or negedge shift_rstn or posedge preload_stb) begin
    if (!shift_rstn)      chain <= '0;
    else if (preload_stb) chain <= preload_val;
    else                  chain <= {chain[L-2:0], shift_data_out};
  end
  assign shift_data_in = chain[L-1];

  // activity monitors (monotonic; compared as deltas)
  int edge_cnt = 0, load_pulses = 0, load_cycles = 0, done_pulses = 0;
  always @(posedge shift_clock) edge_cnt++;
  always @(posedge shift_load)  load_pulses++;
  always @(posedge shift_done)  done_pulses++;
  always @(posedge mclk) if (shift_load) load_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pad_val(input int p);
    return chain[p*16 +: 16];
  endfunction

  task automatic preload(input logic [15:0] p0, p1, p2, p3);
    @(negedge mclk);
    preload_val = {p3, p2, p1, p0};
    preload_stb = 1'b1;
    #1 preload_stb = 1'b0;
  endtask

  task automatic check_pads(input string tag, input logic [15:0] p0, p1, p2, p3);
    check({tag, "_pad0"}, pad_val(0), p0);
    check({tag, "_pad1"}, pad_val(1), p1);
    check({tag, "_pad2"}, pad_val(2), p2);
    check({tag, "_pad3"}, pad_val(3), p3);
  endtask

  // Issue one request; lat counts cycles from the accepting IDLE cycle to shift_done.
  // With mutate set, inputs are scrambled and shift_req dropped right after accept.
  task automatic do_write(input logic [7:0] pad, input logic [15:0] data, input bit mutate,
                          output logic [15:0] cap, output int lat, output bit one_cycle);
    repeat (3) @(negedge mclk);
    cfg_pad_no = pad;
    cfg_shift_data = data;
    shift_req = 1'b1;
    @(posedge mclk);
    lat = 0;
    if (mutate) begin
      @(negedge mclk);
      cfg_pad_no = 8'd3;
      cfg_shift_data = 16'hDEAD;
      shift_req = 1'b0;
      @(posedge mclk);
      lat = 1;
    end
    while (lat < 3000) begin
      #1;
      lat++;
      if (shift_done) break;
      @(posedge mclk);
    end
    cap = capture_data;
    @(negedge mclk);
    shift_req = 1'b0;
    @(posedge mclk);
    #1 one_cycle = !shift_done;
  endtask

  logic [15:0] cap;
  int lat, e0, lp0, lc0, d0;
  bit one;

  initial begin
    // reset state
    repeat (3) @(posedge mclk);
    #1;
    check("rst_ctrl", {shift_done, shift_rstn, shift_clock, shift_load, shift_data_out}, 5'b0);
    check("rst_capture", capture_data, 16'h0);
    @(negedge mclk);
    h_reset_n = 1'b1;
    #1 check("rstn_before_edge", shift_rstn, 1'b0);
    @(posedge mclk);
    #1 check("rstn_after_edge", shift_rstn, 1'b1);

    // pad 2 write
    preload(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    e0 = edge_cnt; lp0 = load_pulses; lc0 = load_cycles; d0 = done_pulses;
    do_write(8'd2, 16'hA5C3, 1'b0, cap, lat, one);
    check("p2_capture", cap, 16'h3333);
    check("p2_latency", lat, LAT_FULL);
    check("p2_done_1cyc", one, 1'b1);
    check("p2_edges", edge_cnt - e0, 64);
    check("p2_load_pulses", load_pulses - lp0, 1);
    check("p2_load_cycles", load_cycles - lc0, CLK_DIV);
    check("p2_done_pulses", done_pulses - d0, 1);
    check_pads("p2", 16'h1111, 16'h2222, 16'hA5C3, 16'h4444);

    // boundary pads
    do_write(8'd0, 16'hFFFF, 1'b0, cap, lat, one);
    check("p0_capture", cap, 16'h1111);
    check("p0_latency", lat, LAT_FULL);
    do_write(8'd3, 16'h0001, 1'b0, cap, lat, one);
    check("p3_capture", cap, 16'h4444);
    check_pads("p3", 16'hFFFF, 16'h2222, 16'hA5C3, 16'h0001);

    // out of range
    e0 = edge_cnt; lp0 = load_pulses; lc0 = load_cycles;
    do_write(8'd4, 16'h9999, 1'b0, cap, lat, one);
    check("oor_latency", lat, 1);
    check("oor_capture", cap, 16'h0);
    check("oor_done_1cyc", one, 1'b1);
    check("oor_edges", edge_cnt - e0, 0);
    check("oor_loads", (load_pulses - lp0) + (load_cycles - lc0), 0);
    check_pads("oor", 16'hFFFF, 16'h2222, 16'hA5C3, 16'h0001);

    // inputs changed and request dropped mid-operation
    do_write(8'd1, 16'h1234, 1'b1, cap, lat, one);
    check("mut_capture", cap, 16'h2222);
    check("mut_latency", lat, LAT_FULL);
    check_pads("mut", 16'hFFFF, 16'h1234, 16'hA5C3, 16'h0001);

    // reset in the middle of a shift
    e0 = edge_cnt; d0 = done_pulses;
    @(negedge mclk);
    cfg_pad_no = 8'd1;
    cfg_shift_data = 16'h5555;
    shift_req = 1'b1;
    for (int i = 0; i < 2000 && (edge_cnt - e0) < 30; i++) @(negedge mclk);
    check("mid_reached_bit30", edge_cnt - e0, 30);
    h_reset_n = 1'b0;
    shift_req = 1'b0;
    #1;
    check("mid_rst_ctrl", {shift_done, shift_rstn, shift_clock, shift_load, shift_data_out}, 5'b0);
    check("mid_rst_capture", capture_data, 16'h0);
    repeat (3) @(negedge mclk);
    check("mid_rst_chain", chain[63:32] | chain[31:0], 32'h0);
    h_reset_n = 1'b1;
    repeat (5) @(negedge mclk);
    check("mid_no_done", done_pulses - d0, 0);
    do_write(8'd1, 16'hBEEF, 1'b0, cap, lat, one);
    check("post_capture", cap, 16'h0);
    check("post_latency", lat, LAT_FULL);
    check_pads("post", 16'h0000, 16'hBEEF, 16'h0000, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_pad_shift_seq.md
Name: gpio_pad_shift_seq

Overview:
- Serial engine behind the GPIO pad-control register block.
- Consumes a shift request, a pad number and 16-bit pad config. Drives the daisy-chained pad shift registers over a 4-wire serial interface and returns the pad's previous 16-bit config.
- Each access is a read-modify-write: the whole chain is rotated once. Every other pad's bits are recirculated unchanged; only the target pad's 16-bit window is replaced.

Parameters:
- NUM_PADS, 44, number of pads in the daisy chain (each pad holds 16 bits); chain length L = NUM_PADS*16.
- CLK_DIV, 4, mclk cycles per shift_clock half-period; minimum 3.

Ports:
- mclk  input  1  system clock
- h_reset_n  input  1  asynchronous active-low reset
- shift_req  input  1  level request from register block; held until shift_done
- cfg_pad_no  input  8  target pad index, 0..NUM_PADS-1
- cfg_shift_data  input  16  new config for target pad
- shift_done  output  1  one-cycle completion pulse (acks shift_req)
- capture_data  output  16  previous config of target pad
- shift_rstn  output  1  pad shift-register reset, active low
- shift_clock  output  1  serial shift clock
- shift_load  output  1  pad load strobe
- shift_data_out  output  1  serial data to pad 0
- shift_data_in  input  1  serial data returning from pad NUM_PADS-1

Behaviour:
- Reset values: shift_done=0, capture_data=0, shift_rstn=0, shift_clock=0, shift_load=0, shift_data_out=0, FSM=IDLE, all counters 0.
- shift_rstn goes to 1 on the first mclk edge after h_reset_n deasserts.
- shift_data_in passes through a 2-flop synchronizer before any use.
- Chain model: ring positions 0..L-1, position 0 is the first flop of pad 0. Pad p bit i sits at position 16p+i. Position L-1 drives shift_data_in.
- FSM states: IDLE, SETUP, LOW, HIGH, LOAD, DONE.
- IDLE:
  - If shift_req=1 and cfg_pad_no<NUM_PADS: latch cfg_pad_no and cfg_shift_data, clear bit counter k, go to SETUP.
  - If shift_req=1 and cfg_pad_no>=NUM_PADS: capture_data<=0, go to DONE. No shift_clock edges are produced.
- Config inputs are sampled only in IDLE; changes mid-operation are ignored.
- SETUP: CLK_DIV cycles, shift_clock=0; lets the synchronizer settle. Go to LOW.
- LOW (entry, step k):
  - Sample the synchronized shift_data_in as bit b.
  - If k lies in the window W = [L-16-16p, L-1-16p]: shift_data_out<=cfg_shift_data[15-(k-Wstart)] (MSB first), and capture_data shifts in b MSB first.
  - Otherwise shift_data_out<=b (recirculate).
  - Hold shift_clock=0 for CLK_DIV cycles, then go to HIGH.
- HIGH: shift_clock=1 for CLK_DIV cycles; the rising edge at entry shifts the chain.
  - On exit, k increments.
  - If k reaches L, go to LOAD; else go to LOW.
  - The sample for step k+1 is taken at LOW entry, at least CLK_DIV>=3 cycles after the edge.
- LOAD: shift_clock=0, shift_load=1 for CLK_DIV cycles, then go to DONE.
- DONE: shift_done=1 for exactly one cycle, shift_load=0, then go to IDLE. IDLE ignores shift_req for that one cycle, because the register block clears shift_req on the ack.
- After the full rotation every non-target pad holds its original value. The target pad holds cfg_shift_data; capture_data holds its old value.
- Latency: shift_done asserts 2*CLK_DIV*(L+1)+1 cycles after the IDLE cycle that accepted the request. Out-of-range requests complete in 1 cycle.
- shift_req dropping mid-operation is ignored; the operation always completes.
- Reset mid-operation: all outputs go to reset values immediately; shift_rstn=0 clears the pads; no shift_done is issued.
- Back-to-back requests: a new request is accepted no earlier than the second cycle after DONE.

Test Plan:
- Reset: assert h_reset_n=0 mid-simulation -> all outputs 0; shift_rstn=1 one mclk after release.
- NUM_PADS=4, CLK_DIV=4, pad model preloaded 16'h1111/2222/3333/4444; write pad 2 with 16'hA5C3 -> capture_data=16'h3333; pads read 1111/2222/A5C3/4444; exactly 64 shift_clock rising edges; one shift_load pulse 4 cycles wide; shift_done at cycle 521.
- Boundaries with the same setup: write pad 0 with 16'hFFFF, then pad 3 with 16'h0001 -> captures 16'h1111 and 16'h4444; no other pad changes.
- Out-of-range: cfg_pad_no=8'd4 -> shift_done 1 cycle after accept; capture_data=0; no shift_clock or shift_load activity.
- Reset mid-shift: assert h_reset_n=0 at bit 30 -> outputs reset, no shift_done. A subsequent write of pad 1 with 16'hBEEF completes normally, with capture_data equal to the pad model's post-reset value.
- Change cfg_pad_no and cfg_shift_data, and drop shift_req, during an active operation -> the original latched request completes unchanged.
